decode_stage: RTL and testbench

- Instruction decode stage, directly downstream of the fetch stage; consumes the fetched 32-bit instruction word and its PC+4.
- Holds the 32x32 register file and the main control decoder.
- Produces a registered ID/EX bundle (operands, immediate, field indices, control bits) with stall/flush support for the pipelined core.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/reg_file.sv | 53 +++++
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings and the
// control bundle carried from decode into execute.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memToReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic [1:0] aluOp;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Two-read / one-write register file with hardwired zero register,
// write-to-read bypass and asynchronous clear.
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int AW      = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rdAddr1_i,
    input  logic [AW-1:0]     rdAddr2_i,
    input  logic              wrEn_i,
    input  logic [AW-1:0]     wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    output logic [DATA_W-1:0] rdData1_o,
    output logic [DATA_W-1:0] rdData2_o
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic              wrLive;

    assign wrLive = wrEn_i && (wrAddr_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrLive) begin
            regs_q[wrAddr_i] <= wrData_i;
        end
    end

    // Bypass lets decode see a value being written back in the same cycle.
    always_comb begin
        rdData1_o = regs_q[rdAddr1_i];
        if (rdAddr1_i == '0) begin
            rdData1_o = '0;
        end else if (wrLive && (wrAddr_i == rdAddr1_i)) begin
            rdData1_o = wrData_i;
        end
    end

    always_comb begin
        rdData2_o = regs_q[rdAddr2_i];
        if (rdAddr2_i == '0) begin
            rdData2_o = '0;
        end else if (wrLive && (wrAddr_i == rdAddr2_i)) begin
            rdData2_o = wrData_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register file read, main control decode and
// the ID/EX pipeline register with stall and flush.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pcPlus4_i,
    input  logic              inValid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wbEn_i,
    input  logic [4:0]        wbAddr_i,
    input  logic [DATA_W-1:0] wbData_i,
    output logic              outValid_o,
    output logic [DATA_W-1:0] rdData1_o,
    output logic [DATA_W-1:0] rdData2_o,
    output logic [31:0]       signImm_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        shamt_o,
    output logic [5:0]        funct_o,
    output logic [31:0]       jumpTarget_o,
    output logic [31:0]       outPcPlus4_o,
    output logic              regDst_o,
    output logic              aluSrc_o,
    output logic              memToReg_o,
    output logic              regWrite_o,
    output logic              memRead_o,
    output logic              memWrite_o,
    output logic              branch_o,
    output logic              jump_o,
    output logic [1:0]        aluOp_o,
    output logic              illegalInstr_o
);

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic              illegal;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [31:0]       signImm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [31:0]       jumpTarget;
        logic [31:0]       pcPlus4;
    } idex_t;

    logic [5:0]        opcode;
    logic [DATA_W-1:0] rfRd1;
    logic [DATA_W-1:0] rfRd2;
    ctrl_t             ctrlRaw;
    logic              illegalRaw;
    idex_t             capture;
    idex_t             bundle_d;
    idex_t             bundle_q;

    assign opcode = instr_i[31:26];

    reg_file #(
        .DATA_W (DATA_W),
        .REG_CNT(REG_CNT),
        .AW     (5)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rdAddr1_i(instr_i[25:21]),
        .rdAddr2_i(instr_i[20:16]),
        .wrEn_i   (wbEn_i),
        .wrAddr_i (wbAddr_i),
        .wrData_i (wbData_i),
        .rdData1_o(rfRd1),
        .rdData2_o(rfRd2)
    );

    always_comb begin
        ctrlRaw    = '0;
        illegalRaw = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrlRaw.regDst   = 1'b1;
                ctrlRaw.regWrite = 1'b1;
                ctrlRaw.aluOp    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrlRaw.aluSrc   = 1'b1;
                ctrlRaw.memToReg = 1'b1;
                ctrlRaw.regWrite = 1'b1;
                ctrlRaw.memRead  = 1'b1;
                ctrlRaw.aluOp    = ALUOP_ADD;
            end
            OP_SW: begin
                ctrlRaw.aluSrc   = 1'b1;
                ctrlRaw.memWrite = 1'b1;
                ctrlRaw.aluOp    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrlRaw.branch = 1'b1;
                ctrlRaw.aluOp  = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrlRaw.aluSrc   = 1'b1;
                ctrlRaw.regWrite = 1'b1;
                ctrlRaw.aluOp    = ALUOP_ADD;
            end
            OP_J: begin
                ctrlRaw.jump = 1'b1;
            end
            default: begin
                illegalRaw = 1'b1;
            end
        endcase
    end

    // A bubble on the input must never carry control bits into execute.
    always_comb begin
        capture            = '0;
        capture.valid      = inValid_i;
        capture.ctrl       = inValid_i ? ctrlRaw : '0;
        capture.illegal    = inValid_i & illegalRaw;
        capture.rd1        = rfRd1;
        capture.rd2        = rfRd2;
        capture.signImm    = {{16{instr_i[15]}}, instr_i[15:0]};
        capture.rs         = instr_i[25:21];
        capture.rt         = instr_i[20:16];
        capture.rd         = instr_i[15:11];
        capture.shamt      = instr_i[10:6];
        capture.funct      = instr_i[5:0];
        capture.jumpTarget = {pcPlus4_i[31:28], instr_i[25:0], 2'b00};
        capture.pcPlus4    = pcPlus4_i;
    end

    always_comb begin
        bundle_d = bundle_q;
        if (flush_i) begin
            bundle_d         = capture;
            bundle_d.valid   = 1'b0;
            bundle_d.ctrl    = '0;
            bundle_d.illegal = 1'b0;
        end else if (!stall_i) begin
            bundle_d = capture;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign outValid_o     = bundle_q.valid;
    assign rdData1_o      = bundle_q.rd1;
    assign rdData2_o      = bundle_q.rd2;
    assign signImm_o      = bundle_q.signImm;
    assign rs_o           = bundle_q.rs;
    assign rt_o           = bundle_q.rt;
    assign rd_o           = bundle_q.rd;
    assign shamt_o        = bundle_q.shamt;
    assign funct_o        = bundle_q.funct;
    assign jumpTarget_o   = bundle_q.jumpTarget;
    assign outPcPlus4_o   = bundle_q.pcPlus4;
    assign regDst_o       = bundle_q.ctrl.regDst;
    assign aluSrc_o       = bundle_q.ctrl.aluSrc;
    assign memToReg_o     = bundle_q.ctrl.memToReg;
    assign regWrite_o     = bundle_q.ctrl.regWrite;
    assign memRead_o      = bundle_q.ctrl.memRead;
    assign memWrite_o     = bundle_q.ctrl.memWrite;
    assign branch_o       = bundle_q.ctrl.branch;
    assign jump_o         = bundle_q.ctrl.jump;
    assign aluOp_o        = bundle_q.ctrl.aluOp;
    assign illegalInstr_o = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: expected ID/EX bundles are
// queued as each step is driven and compared after the capturing edge.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        inValid;
    logic        stall;
    logic        flush;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        outValid;
    logic [31:0] rdData1;
    logic [31:0] rdData2;
    logic [31:0] signImm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] jumpTarget;
    logic [31:0] outPcPlus4;
    logic        regDst;
    logic        aluSrc;
    logic        memToReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        jump;
    logic [1:0]  aluOp;
    logic        illegalInstr;

    typedef struct {
        logic        valid;
        logic [9:0]  ctrl;
        logic        illegal;
        logic        checkData;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [25:0] fields;
        logic [31:0] jt;
        logic [31:0] pc4;
    } expT;

    expT         expQ[$];
    expT         lastExp;
    logic [31:0] modelRegs [32];
    int          compared;
    int          mismatched;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr),
        .pcPlus4_i     (pcPlus4),
        .inValid_i     (inValid),
        .stall_i       (stall),
        .flush_i       (flush),
        .wbEn_i        (wbEn),
        .wbAddr_i      (wbAddr),
        .wbData_i      (wbData),
        .outValid_o    (outValid),
        .rdData1_o     (rdData1),
        .rdData2_o     (rdData2),
        .signImm_o     (signImm),
        .rs_o          (rs),
        .rt_o          (rt),
        .rd_o          (rd),
        .shamt_o       (shamt),
        .funct_o       (funct),
        .jumpTarget_o  (jumpTarget),
        .outPcPlus4_o  (outPcPlus4),
        .regDst_o      (regDst),
        .aluSrc_o      (aluSrc),
        .memToReg_o    (memToReg),
        .regWrite_o    (regWrite),
        .memRead_o     (memRead),
        .memWrite_o    (memWrite),
        .branch_o      (branch),
        .jump_o        (jump),
        .aluOp_o       (aluOp),
        .illegalInstr_o(illegalInstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control vector order: regDst aluSrc memToReg regWrite memRead memWrite branch jump aluOp[1:0]
    function automatic logic [9:0] expCtrl(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b1001_0000_10;
            6'h23:   return 10'b0111_1000_00;
            6'h2B:   return 10'b0100_0100_00;
            6'h04:   return 10'b0000_0010_01;
            6'h08:   return 10'b0101_0000_00;
            6'h02:   return 10'b0000_0001_00;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic isKnown(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wbEn && wbAddr != 5'd0 && wbAddr == idx) return wbData;
        return modelRegs[idx];
    endfunction

    task automatic applyStimulus(input logic [31:0] iw, input logic [31:0] pc4,
                                 input logic v, input logic st, input logic fl,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        expT e;
        instr   = iw;
        pcPlus4 = pc4;
        inValid = v;
        stall   = st;
        flush   = fl;
        wbEn    = we;
        wbAddr  = wa;
        wbData  = wd;
        #0;
        e.valid     = v;
        e.ctrl      = v ? expCtrl(iw[31:26]) : 10'b0;
        e.illegal   = v && !isKnown(iw[31:26]);
        e.checkData = 1'b1;
        e.rd1       = modelRead(iw[25:21]);
        e.rd2       = modelRead(iw[20:16]);
        e.imm       = {{16{iw[15]}}, iw[15:0]};
        e.fields    = iw[25:0];
        e.jt        = {pc4[31:28], iw[25:0], 2'b00};
        e.pc4       = pc4;
        if (fl) begin
            e.valid     = 1'b0;
            e.ctrl      = 10'b0;
            e.illegal   = 1'b0;
            e.checkData = 1'b0;
        end else if (st) begin
            e = lastExp;
        end
        lastExp = e;
        expQ.push_back(e);
        if (we && wa != 5'd0) modelRegs[wa] = wd;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        expT e;
        if (expQ.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        check("valid", {31'b0, outValid}, {31'b0, e.valid});
        check("ctrl", {22'b0, regDst, aluSrc, memToReg, regWrite, memRead, memWrite,
                       branch, jump, aluOp}, {22'b0, e.ctrl});
        check("illegal", {31'b0, illegalInstr}, {31'b0, e.illegal});
        if (e.checkData) begin
            check("rdData1", rdData1, e.rd1);
            check("rdData2", rdData2, e.rd2);
            check("signImm", signImm, e.imm);
            check("fields", {6'b0, rs, rt, rd, shamt, funct}, {6'b0, e.fields});
            check("jumpTarget", jumpTarget, e.jt);
            check("pcPlus4", outPcPlus4, e.pc4);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ctl"}, {17'b0, outValid, regDst, aluSrc, memToReg, regWrite, memRead,
                              memWrite, branch, jump, aluOp, illegalInstr, 2'b0}, 32'h0);
        check({tag, "_rd1"}, rdData1, 32'h0);
        check({tag, "_rd2"}, rdData2, 32'h0);
        check({tag, "_imm"}, signImm, 32'h0);
        check({tag, "_fields"}, {6'b0, rs, rt, rd, shamt, funct}, 32'h0);
        check({tag, "_jt"}, jumpTarget, 32'h0);
        check({tag, "_pc4"}, outPcPlus4, 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        rst = 1'b1; instr = 32'h0; pcPlus4 = 32'h0; inValid = 1'b0;
        stall = 1'b0; flush = 1'b0; wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'h0;
        lastExp = '{default: '0};
        #12;
        checkAllZero("por");
        rst = 1'b0;

        // add $10,$8,$9 with same-cycle writeback of $8 (bypass)
        applyStimulus(32'h0109_5020, 32'h0000_0104, 1, 0, 0, 1, 5'd8, 32'h0000_00AA);
        check("bypass_rd1", rdData1, 32'h0000_00AA);
        // write to $0 discarded; lw $2,-4($0)
        applyStimulus(32'h8C02_FFFC, 32'h0000_0108, 1, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        check("lw_zero_rd1", rdData1, 32'h0);
        check("lw_imm", signImm, 32'hFFFF_FFFC);
        // addi and beq with registered (non-bypassed) operands
        applyStimulus(32'h2109_0003, 32'h0000_010C, 1, 0, 0, 1, 5'd9, 32'h0000_1234);
        applyStimulus(32'h1109_FFFE, 32'h0000_0110, 1, 0, 0, 0, 5'd0, 32'h0);
        check("beq_rd2", rdData2, 32'h0000_1234);
        // stall three cycles with changing Instr and a writeback to $9
        applyStimulus(32'hAC00_0000, 32'h0000_0114, 1, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(32'h0800_0001, 32'h0000_0118, 1, 1, 0, 1, 5'd9, 32'h0000_5678);
        applyStimulus(32'hFC00_0000, 32'h0000_011C, 0, 1, 0, 0, 5'd0, 32'h0);
        // capture after stall sees the writeback completed during the stall
        applyStimulus(32'h0109_5020, 32'h0000_0120, 1, 0, 0, 0, 5'd0, 32'h0);
        check("post_stall_rd2", rdData2, 32'h0000_5678);
        // flush wins over stall
        applyStimulus(32'h0109_5020, 32'h0000_0124, 1, 1, 1, 0, 5'd0, 32'h0);
        // jump target and illegal opcode
        applyStimulus(32'h0800_0010, 32'h4000_0004, 1, 0, 0, 0, 5'd0, 32'h0);
        check("j_target", jumpTarget, 32'h4000_0040);
        applyStimulus(32'hFC00_0000, 32'h4000_0008, 1, 0, 0, 0, 5'd0, 32'h0);
        check("illegal_flag", {31'b0, illegalInstr}, 32'h1);
        // sw with InValid=0 is a bubble
        applyStimulus(32'hAC00_0000, 32'h4000_000C, 0, 0, 0, 0, 5'd0, 32'h0);
        // write $5, leave outputs nonzero, then reset asynchronously mid-stall
        applyStimulus(32'h00A0_0000, 32'h0000_0200, 1, 0, 0, 1, 5'd5, 32'h0000_0055);
        check("pre_reset_rd1", rdData1, 32'h0000_0055);
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        lastExp = '{default: '0};
        // $5 must read back cleared
        applyStimulus(32'h00A0_0000, 32'h0000_0300, 1, 0, 0, 0, 5'd0, 32'h0);
        check("post_reset_rd1", rdData1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
